// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - byte-stream input and instruction-memory write port of the Hack program loader
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  start;
  logic [15:0]           length;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;
  logic                  wr_en;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  cpu_reset;

  modport master (
    output start, length, in_data, in_valid,
    input  in_ready, wr_addr, wr_data, wr_en, busy, done, error, cpu_reset
  );

  modport slave (
    input  start, length, in_data, in_valid,
    output in_ready, wr_addr, wr_data, wr_en, busy, done, error, cpu_reset
  );
endinterface

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - assembles big-endian words from a byte stream into Hack instruction memory
// and holds the CPU in reset until a complete load has finished.
module rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic          CLK,
  input  logic          reset,
  rom_loader_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  state_t                state, state_next;
  logic                  accept_start;
  logic                  too_long;
  logic                  last_word;
  logic [7:0]            hi_byte;
  logic [15:0]           wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_inc;
  logic [ADDR_WIDTH:0]   len_q;

  assign too_long  = {1'b0, bus.length} > MAX_LEN;
  assign count_inc = count + (ADDR_WIDTH+1)'(1);
  assign last_word = (count_inc == len_q);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_start = 1'b1;
          if (bus.length == 16'd0) state_next = DONE;
          else if (too_long)       state_next = IDLE;
          else                     state_next = HI;
        end
      end
      HI:      if (bus.in_valid) state_next = LO;
      LO:      if (bus.in_valid) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : HI;
      default: state_next = IDLE;
    endcase
  end

  // Address holds on the last word so a full-size load ends at the top address without wrapping.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hi_byte   <= 8'd0;
      wr_data_q <= 16'd0;
      wr_addr_q <= '0;
      count     <= '0;
      len_q     <= '0;
      bus.error <= 1'b0;
    end else begin
      if (accept_start) begin
        bus.error <= too_long;
        wr_addr_q <= '0;
        count     <= '0;
        len_q     <= bus.length[ADDR_WIDTH:0];
      end
      if (state == HI && bus.in_valid) hi_byte <= bus.in_data;
      if (state == LO && bus.in_valid) wr_data_q <= {hi_byte, bus.in_data};
      if (state == WRITE) begin
        count <= count_inc;
        if (!last_word) wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = (state == HI) || (state == LO);
  assign bus.busy      = (state == HI) || (state == LO) || (state == WRITE);
  assign bus.wr_en     = (state == WRITE);
  assign bus.done      = (state == DONE);
  assign bus.cpu_reset = (state != DONE);
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader: full-size instance plus a 16-word instance
// used to run a maximum-length load to its top address.
`timescale 1ns/1ps
module tb_rom_loader;

  logic        CLK = 1'b0;
  logic        reset;
  logic        sel;
  logic        start;
  logic [15:0] length;
  logic [7:0]  in_data;
  logic        in_valid;

  always #5 CLK = ~CLK;

  rom_loader_if #(.ADDR_WIDTH(15)) ifc ();
  rom_loader_if #(.ADDR_WIDTH(4))  sifc ();

  rom_loader #(.ADDR_WIDTH(15)) dut (.CLK(CLK), .reset(reset), .bus(ifc.slave));
  rom_loader #(.ADDR_WIDTH(4))  sdut (.CLK(CLK), .reset(reset), .bus(sifc.slave));

  assign ifc.start     = start & ~sel;
  assign ifc.length    = length;
  assign ifc.in_data   = in_data;
  assign ifc.in_valid  = in_valid & ~sel;
  assign sifc.start    = start & sel;
  assign sifc.length   = length;
  assign sifc.in_data  = in_data;
  assign sifc.in_valid = in_valid & sel;

  logic        rdy, wen, bsy, dn, err, cpur;
  logic [14:0] waddr;
  logic [15:0] wdata;
  assign rdy   = sel ? sifc.in_ready  : ifc.in_ready;
  assign wen   = sel ? sifc.wr_en     : ifc.wr_en;
  assign bsy   = sel ? sifc.busy      : ifc.busy;
  assign dn    = sel ? sifc.done      : ifc.done;
  assign err   = sel ? sifc.error     : ifc.error;
  assign cpur  = sel ? sifc.cpu_reset : ifc.cpu_reset;
  assign waddr = sel ? {11'd0, sifc.wr_addr} : ifc.wr_addr;
  assign wdata = sel ? sifc.wr_data   : ifc.wr_data;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  nwr      = 0;

  always @(negedge CLK) begin
    if (!reset && wen) begin
      nwr++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h@%h required=no write", wdata, waddr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (waddr !== e.a || wdata !== e.d) begin
          failures++;
          $display("FAIL write actual=%h@%h required=%h@%h", wdata, waddr, e.d, e.a);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [14:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] len);
    start  = 1'b1;
    length = len;
    @(negedge CLK);
    start  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  // Returns at the negedge just after the byte was taken; in_valid stays high unless gap is set.
  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!rdy && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (!rdy) begin
      failures++;
      $display("FAIL send_timeout actual=in_ready 0 required=in_ready 1");
    end
    @(negedge CLK);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic wait_done(input int bound);
    int t;
    t = 0;
    while (!dn && t < bound) begin
      @(negedge CLK);
      t++;
    end
    in_valid = 1'b0;
    chk("done_reached", {31'd0, dn}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  {31'd0, rdy},  32'd0);
    chk({tag, "_wr_en"},     {31'd0, wen},  32'd0);
    chk({tag, "_busy"},      {31'd0, bsy},  32'd0);
    chk({tag, "_done"},      {31'd0, dn},   32'd0);
    chk({tag, "_error"},     {31'd0, err},  32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpur}, 32'd1);
    chk({tag, "_wr_addr"},   {17'd0, waddr}, 32'd0);
    chk({tag, "_wr_data"},   {16'd0, wdata}, 32'd0);
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    sel      = 1'b0;
    start    = 1'b0;
    length   = 16'd0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge CLK);

    // two words, in_valid held high
    base = nwr;
    push(15'h0000, 16'h1234);
    push(15'h0001, 16'h5678);
    do_start(16'd2);
    chk("start_busy",     {31'd0, bsy}, 32'd1);
    chk("start_in_ready", {31'd0, rdy}, 32'd1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    chk("wr_en_after_lo", {31'd0, wen}, 32'd1);
    send(8'h56, 1'b0);
    send(8'h78, 1'b0);
    wait_done(20);
    chk("t1_cpu_reset", {31'd0, cpur}, 32'd0);
    chk("t1_busy",      {31'd0, bsy},  32'd0);
    chk("t1_writes",    nwr - base,    32'd2);

    // same load with an idle cycle between bytes
    base = nwr;
    push(15'h0000, 16'h1234);
    push(15'h0001, 16'h5678);
    do_start(16'd2);
    chk("t2_done_cleared", {31'd0, dn}, 32'd0);
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    send(8'h56, 1'b1);
    send(8'h78, 1'b1);
    wait_done(20);
    chk("t2_writes", nwr - base, 32'd2);
    chk("t2_queue",  exp_q.size(), 32'd0);

    // zero length, illegal length, maximum legal length accepted
    base = nwr;
    do_start(16'd0);
    chk("len0_done",      {31'd0, dn},   32'd1);
    chk("len0_cpu_reset", {31'd0, cpur}, 32'd0);
    do_start(16'h8001);
    chk("ill_error",     {31'd0, err},  32'd1);
    chk("ill_done",      {31'd0, dn},   32'd0);
    chk("ill_cpu_reset", {31'd0, cpur}, 32'd1);
    chk("ill_in_ready",  {31'd0, rdy},  32'd0);
    chk("ill_busy",      {31'd0, bsy},  32'd0);
    @(negedge CLK);
    chk("ill_in_ready_hold", {31'd0, rdy}, 32'd0);
    chk("t3_writes", nwr - base, 32'd0);
    do_start(16'h8000);
    chk("max_error", {31'd0, err}, 32'd0);
    chk("max_busy",  {31'd0, bsy}, 32'd1);
    pulse_reset();

    // reset during the second word's low-byte wait
    base = nwr;
    push(15'h0000, 16'h1111);
    do_start(16'd2);
    send(8'h11, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    in_valid = 1'b0;
    chk("t4_first_written", nwr - base, 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_async_cpu_reset", {31'd0, cpur}, 32'd1);
    @(negedge CLK);
    chk_reset_vals("midrst");
    reset = 1'b0;
    @(negedge CLK);
    base = nwr;
    push(15'h0000, 16'hABCD);
    do_start(16'd1);
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    wait_done(20);
    chk("t4_writes", nwr - base, 32'd1);

    // start pulsed while busy is ignored
    base = nwr;
    push(15'h0000, 16'h0102);
    push(15'h0001, 16'h0304);
    push(15'h0002, 16'h0506);
    do_start(16'd3);
    do_start(16'd1);
    chk("t5_busy", {31'd0, bsy}, 32'd1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("t5_not_done", {31'd0, dn}, 32'd0);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    wait_done(20);
    chk("t5_writes", nwr - base, 32'd3);

    // full-size load on the 16-word instance: ends at top address, no wrap
    pulse_reset();
    sel = 1'b1;
    @(negedge CLK);
    base = nwr;
    for (int k = 0; k < 16; k++) push(15'(k), {8'(k), 8'(k * 3 + 1)});
    do_start(16'd16);
    for (int k = 0; k < 16; k++) begin
      send(8'(k), 1'b0);
      send(8'(k * 3 + 1), 1'b0);
    end
    wait_done(20);
    chk("full_writes",  nwr - base,    32'd16);
    chk("full_wr_addr", {17'd0, waddr}, 32'd15);
    chk("full_queue",   exp_q.size(),  32'd0);
    do_start(16'd17);
    chk("small_ill_error", {31'd0, err}, 32'd1);
    chk("small_ill_busy",  {31'd0, bsy}, 32'd0);

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
